// File: rtl/maze_sprite_compositor_if.sv
// Pixel stream, sprite table, map RAM port and game-state outputs of the maze compositor.
// The master side is the video source, map RAM and game logic; the slave side is the compositor.
interface maze_sprite_compositor_if #(
    parameter int N_SPRITES = 5
);
    logic                     frame_stb;
    logic                     display_enabled;
    logic [8:0]               sx;
    logic [8:0]               sy;
    logic [N_SPRITES*9-1:0]   spr_x;
    logic [N_SPRITES*9-1:0]   spr_y;
    logic [N_SPRITES*12-1:0]  spr_color;
    logic [N_SPRITES-1:0]     spr_en;
    logic [10:0]              tile_raddr;
    logic [3:0]               tile_rdata;
    logic                     tile_we;
    logic [10:0]              tile_waddr;
    logic [3:0]               tile_wdata;
    logic [3:0]               R;
    logic [3:0]               G;
    logic [3:0]               B;
    logic [15:0]              score;
    logic [8:0]               pellets_left;
    logic                     level_clear;
    logic                     power_stb;
    logic [N_SPRITES-1:0]     collide;

    modport master (
        output frame_stb, display_enabled, sx, sy, spr_x, spr_y, spr_color, spr_en, tile_rdata,
        input  tile_raddr, tile_we, tile_waddr, tile_wdata, R, G, B,
               score, pellets_left, level_clear, power_stb, collide
    );

    modport slave (
        input  frame_stb, display_enabled, sx, sy, spr_x, spr_y, spr_color, spr_en, tile_rdata,
        output tile_raddr, tile_we, tile_waddr, tile_wdata, R, G, B,
               score, pellets_left, level_clear, power_stb, collide
    );
endinterface

// File: rtl/maze_sprite_compositor.sv
// Composites N_SPRITES rectangles over the tile maze (2-cycle pixel pipe) and runs the
// once-per-frame pellet-eating FSM that borrows the map RAM port during blanking.
module maze_sprite_compositor #(
    parameter int          N_SPRITES    = 5,
    parameter int          SPRITE_W     = 8,
    parameter int          SPRITE_H     = 8,
    parameter int          TILE         = 8,
    parameter int          MAP_W_TILES  = 32,
    parameter int          MAP_H_TILES  = 36,
    parameter int          PELLET_COUNT = 244,
    parameter int          PELLET_PTS   = 10,
    parameter int          POWER_PTS    = 50,
    parameter logic [15:0] SCORE_INIT   = 16'h0000  // score after reset; nonzero only for bring-up
) (
    input logic                     vga_pix_clk,
    input logic                     rst,
    maze_sprite_compositor_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PEND, READ, CHECK, WRITE} state_e;

    state_e               state_q;
    logic [8:0]           sx_q, sy_q;
    logic                 de_q;
    logic [11:0]          rgb_q, rgb_d, tile_rgb;
    logic [8:0]           px, py;
    logic [N_SPRITES-1:0] hit, sticky_q, collide_q;
    logic [15:0]          score_q;
    logic [16:0]          score_sum;
    logic [8:0]           pellets_q;
    logic                 clear_q, power_q, we_q;
    logic [10:0]          eat_addr_q, eat_addr_d, render_addr;
    logic [9:0]           cx, cy;

    // Stage 0: address for the pixel now on sx/sy; READ steals it for the player's centre tile.
    assign render_addr    = 11'((32'(bus.sy) / TILE) * MAP_W_TILES + 32'(bus.sx) / TILE);
    assign bus.tile_raddr = (state_q == READ) ? eat_addr_q : render_addr;

    assign cx         = ({1'b0, bus.spr_x[8:0]} + 10'(SPRITE_W / 2)) / 10'(TILE);
    assign cy         = ({1'b0, bus.spr_y[8:0]} + 10'(SPRITE_H / 2)) / 10'(TILE);
    assign eat_addr_d = 11'(32'(cy) * MAP_W_TILES + 32'(cx));

    // Stage 1: sprite bounds in 10 bits so a sprite near x=511 does not wrap onto column 0.
    always_comb begin
        for (int i = 0; i < N_SPRITES; i++) begin
            hit[i] = bus.spr_en[i]
                && ({1'b0, bus.spr_x[9*i +: 9]} <= {1'b0, sx_q})
                && ({1'b0, sx_q} < {1'b0, bus.spr_x[9*i +: 9]} + 10'(SPRITE_W))
                && ({1'b0, bus.spr_y[9*i +: 9]} <= {1'b0, sy_q})
                && ({1'b0, sy_q} < {1'b0, bus.spr_y[9*i +: 9]} + 10'(SPRITE_H));
        end
    end

    always_comb begin
        px = sx_q & 9'(TILE - 1);
        py = sy_q & 9'(TILE - 1);
        case (bus.tile_rdata)
            4'd1:    tile_rgb = 12'h00F;
            4'd2:    tile_rgb = (px >= 9'd3 && px <= 9'd4 && py >= 9'd3 && py <= 9'd4) ? 12'hFB8 : 12'h000;
            4'd3:    tile_rgb = (px >= 9'd2 && px <= 9'd5 && py >= 9'd2 && py <= 9'd5) ? 12'hFB8 : 12'h000;
            default: tile_rgb = 12'h000;
        endcase
        rgb_d = tile_rgb;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) rgb_d = bus.spr_color[12*i +: 12];
        end
        if (!de_q) rgb_d = 12'h000;
    end

    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            sx_q      <= '0;
            sy_q      <= '0;
            de_q      <= 1'b0;
            rgb_q     <= '0;
            sticky_q  <= '0;
            collide_q <= '0;
        end else begin
            sx_q  <= bus.sx;
            sy_q  <= bus.sy;
            de_q  <= bus.display_enabled;
            rgb_q <= rgb_d;
            if (bus.frame_stb) begin
                collide_q <= sticky_q;
                sticky_q  <= '0;
            end else if (de_q) begin
                sticky_q <= sticky_q | (hit & {N_SPRITES{hit[0]}} & ~N_SPRITES'(1));
            end
        end
    end

    assign score_sum = {1'b0, score_q}
                     + ((bus.tile_rdata == 4'd3) ? 17'(POWER_PTS) : 17'(PELLET_PTS));

    // Eat FSM: the write strobe and score updates are registered on CHECK->WRITE,
    // so they are all visible together during the single WRITE cycle.
    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            score_q    <= SCORE_INIT;
            pellets_q  <= 9'(PELLET_COUNT);
            clear_q    <= 1'b0;
            power_q    <= 1'b0;
            we_q       <= 1'b0;
            eat_addr_q <= '0;
        end else begin
            we_q    <= 1'b0;
            power_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.frame_stb) state_q <= PEND;
                PEND: if (!bus.display_enabled) begin
                    eat_addr_q <= eat_addr_d;
                    state_q    <= (cy >= 10'(MAP_H_TILES)) ? IDLE : READ;
                end
                READ: state_q <= CHECK;
                CHECK: if (bus.tile_rdata == 4'd2 || bus.tile_rdata == 4'd3) begin
                    state_q <= WRITE;
                    we_q    <= 1'b1;
                    power_q <= (bus.tile_rdata == 4'd3);
                    score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    if (pellets_q != 9'd0) pellets_q <= pellets_q - 9'd1;
                    if (pellets_q == 9'd1) clear_q <= 1'b1;
                end else begin
                    state_q <= IDLE;
                end
                WRITE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tile_we      = we_q;
    assign bus.tile_waddr   = eat_addr_q;
    assign bus.tile_wdata   = 4'd0;
    assign {bus.R, bus.G, bus.B} = rgb_q;
    assign bus.score        = score_q;
    assign bus.pellets_left = pellets_q;
    assign bus.level_clear  = clear_q;
    assign bus.power_stb    = power_q;
    assign bus.collide      = collide_q;
endmodule

// File: tb/tb_maze_sprite_compositor.sv
// Scoreboard bench: stimulus queues expected pixels, state values and map writes;
// the negedge monitor pops and compares them against two compositor instances.
module tb_maze_sprite_compositor;
    localparam int NS = 5;
    localparam int K_RGB = 0, K_SCORE = 1, K_PELL = 2, K_CLR = 3, K_COL = 4, K_PWR = 5, K_WE = 6,
                   K_PCNT = 7, K_MEM = 8, K_SSCORE = 9, K_SPELL = 10, K_SCLR = 11;

    typedef struct {
        int          cyc;
        int          kind;
        int          aux;
        logic [31:0] exp;
        string       name;
    } exp_t;

    typedef struct packed {
        logic [10:0] addr;
        logic [3:0]  data;
        logic [15:0] score;
        logic [8:0]  pell;
        logic        clr;
        logic        pwr;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    exp_t        exq[$];
    wr_t         wq0[$], wq1[$];
    int          n_chk = 0, n_pass = 0, pwr_cnt = 0;
    bit          done = 1'b0;
    logic [3:0]  mem0 [2048];
    logic [3:0]  mem1 [2048];
    logic        poke0_en = 1'b0, poke1_en = 1'b0;
    logic [10:0] poke_addr = '0;
    logic [3:0]  poke_data = '0;
    logic [31:0] act;
    wr_t         wact;

    maze_sprite_compositor_if #(.N_SPRITES(NS)) b0 ();
    maze_sprite_compositor_if #(.N_SPRITES(NS)) b1 ();

    maze_sprite_compositor u_dut (.vga_pix_clk(clk), .rst(rst), .bus(b0));
    maze_sprite_compositor #(.PELLET_COUNT(1), .SCORE_INIT(16'hFFFA)) u_sat (
        .vga_pix_clk(clk), .rst(rst), .bus(b1));

    assign b1.frame_stb       = b0.frame_stb;
    assign b1.display_enabled = b0.display_enabled;
    assign b1.sx              = b0.sx;
    assign b1.sy              = b0.sy;
    assign b1.spr_x           = b0.spr_x;
    assign b1.spr_y           = b0.spr_y;
    assign b1.spr_color       = b0.spr_color;
    assign b1.spr_en          = b0.spr_en;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Map RAMs: all-wall main map with a few pellet tiles, empty map for the saturation instance.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 2048; i++) begin
                mem0[i] <= 4'd1;
                mem1[i] <= 4'd0;
            end
            mem0[429] <= 4'd2;
            mem0[430] <= 4'd2;
            mem0[431] <= 4'd3;
            mem0[432] <= 4'd5;
        end
        if (poke0_en) mem0[poke_addr] <= poke_data;
        if (poke1_en) mem1[poke_addr] <= poke_data;
        if (b0.tile_we) mem0[b0.tile_waddr] <= b0.tile_wdata;
        if (b1.tile_we) mem1[b1.tile_waddr] <= b1.tile_wdata;
        b0.tile_rdata <= mem0[b0.tile_raddr];
        b1.tile_rdata <= mem1[b1.tile_raddr];
    end

    function automatic logic [31:0] actual(int kind, int aux);
        case (kind)
            K_RGB:    return 32'({b0.R, b0.G, b0.B});
            K_SCORE:  return 32'(b0.score);
            K_PELL:   return 32'(b0.pellets_left);
            K_CLR:    return 32'(b0.level_clear);
            K_COL:    return 32'(b0.collide);
            K_PWR:    return 32'(b0.power_stb);
            K_WE:     return 32'(b0.tile_we);
            K_PCNT:   return 32'(pwr_cnt);
            K_MEM:    return 32'(mem0[aux]);
            K_SSCORE: return 32'(b1.score);
            K_SPELL:  return 32'(b1.pellets_left);
            K_SCLR:   return 32'(b1.level_clear);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, a, e, cyc);
    endtask

    always @(negedge clk) begin
        for (int i = exq.size() - 1; i >= 0; i--) begin
            if (exq[i].cyc == cyc) begin
                act = actual(exq[i].kind, exq[i].aux);
                chk(exq[i].name, 64'(act), 64'(exq[i].exp));
                exq.delete(i);
            end
        end
        if (b0.tile_we) begin
            wact = {b0.tile_waddr, b0.tile_wdata, b0.score, b0.pellets_left, b0.level_clear, b0.power_stb};
            if (wq0.size() == 0) begin
                n_chk++;
                $display("FAIL write0_unexpected: got write addr %0d at cycle %0d, expected none", b0.tile_waddr, cyc);
            end else chk("write0 {addr,data,score,pell,clr,pwr}", 64'(wact), 64'(wq0.pop_front()));
        end
        if (b1.tile_we) begin
            wact = {b1.tile_waddr, b1.tile_wdata, b1.score, b1.pellets_left, b1.level_clear, b1.power_stb};
            if (wq1.size() == 0) begin
                n_chk++;
                $display("FAIL write1_unexpected: got write addr %0d at cycle %0d, expected none", b1.tile_waddr, cyc);
            end else chk("write1 {addr,data,score,pell,clr,pwr}", 64'(wact), 64'(wq1.pop_front()));
        end
        if (b0.power_stb) pwr_cnt++;
        if (done) begin
            foreach (exq[i]) begin
                n_chk++;
                $display("FAIL %s: never sampled, expected %0h at cycle %0d", exq[i].name, exq[i].exp, exq[i].cyc);
            end
            foreach (wq0[i]) begin
                n_chk++;
                $display("FAIL write0_missing: got no write, expected addr %0d", wq0[i].addr);
            end
            foreach (wq1[i]) begin
                n_chk++;
                $display("FAIL write1_missing: got no write, expected addr %0d", wq1[i].addr);
            end
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(int dly, int kind, int aux, logic [31:0] v, string nm);
        exp_t e;
        e.cyc = cyc + dly; e.kind = kind; e.aux = aux; e.exp = v; e.name = nm;
        exq.push_back(e);
    endtask

    task automatic pix(int x, int y, logic de, logic [11:0] rgb, string nm);
        b0.sx = 9'(x);
        b0.sy = 9'(y);
        b0.display_enabled = de;
        expect_at(2, K_RGB, 0, 32'(rgb), nm);
        tick();
    endtask

    task automatic frame(logic [NS-1:0] col);
        b0.frame_stb = 1'b1;
        b0.display_enabled = 1'b0;
        b0.sx = '0;
        b0.sy = '0;
        expect_at(1, K_COL, 0, 32'(col), "collide");
        tick();
        b0.frame_stb = 1'b0;
        repeat (6) tick();
    endtask

    task automatic poke(bit which, int a, logic [3:0] d);
        poke_addr = 11'(a);
        poke_data = d;
        if (which) poke1_en = 1'b1;
        else poke0_en = 1'b1;
        tick();
        poke0_en = 1'b0;
        poke1_en = 1'b0;
    endtask

    task automatic sprite(int i, int x, int y, logic [11:0] c);
        b0.spr_x[9*i +: 9]      = 9'(x);
        b0.spr_y[9*i +: 9]      = 9'(y);
        b0.spr_color[12*i +: 12] = c;
    endtask

    task automatic expect_reset(int dly);
        expect_at(dly, K_RGB, 0, 32'h000, "rst_rgb");
        expect_at(dly, K_SCORE, 0, 32'd0, "rst_score");
        expect_at(dly, K_PELL, 0, 32'd244, "rst_pellets");
        expect_at(dly, K_CLR, 0, 32'd0, "rst_level_clear");
        expect_at(dly, K_COL, 0, 32'd0, "rst_collide");
        expect_at(dly, K_PWR, 0, 32'd0, "rst_power_stb");
        expect_at(dly, K_WE, 0, 32'd0, "rst_tile_we");
        expect_at(dly, K_SSCORE, 0, 32'hFFFA, "rst_sat_score");
        expect_at(dly, K_SPELL, 0, 32'd1, "rst_sat_pellets");
        expect_at(dly, K_SCLR, 0, 32'd0, "rst_sat_level_clear");
    endtask

    initial begin
        b0.frame_stb = 1'b0;
        b0.display_enabled = 1'b0;
        b0.sx = '0;
        b0.sy = '0;
        b0.spr_x = '0;
        b0.spr_y = '0;
        b0.spr_color = '0;
        b0.spr_en = '0;
        rst = 1'b1;
        repeat (3) tick();
        expect_reset(0);
        tick();
        rst = 1'b0;
        tick();

        // Two frames, no sprites: walls everywhere, no eating (player centre tile 0 is a wall).
        frame('0);
        frame('0);
        pix(10, 20, 1'b1, 12'h00F, "wall_10_20");
        pix(255, 150, 1'b1, 12'h00F, "wall_255_150");
        pix(300, 200, 1'b0, 12'h000, "blank_300_200");
        // Pellet tile 430, power tile 431, code 5 at 432 (row 13, y 104..111).
        pix(115, 107, 1'b1, 12'hFB8, "pellet_px3");
        pix(116, 108, 1'b1, 12'hFB8, "pellet_px4");
        pix(117, 107, 1'b1, 12'h000, "pellet_px5_off");
        pix(114, 107, 1'b1, 12'h000, "pellet_px2_off");
        pix(122, 106, 1'b1, 12'hFB8, "power_px2");
        pix(125, 109, 1'b1, 12'hFB8, "power_px5");
        pix(126, 107, 1'b1, 12'h000, "power_px6_off");
        pix(122, 104, 1'b1, 12'h000, "power_py0_off");
        pix(131, 107, 1'b1, 12'h000, "code5_black");
        expect_at(0, K_SCORE, 0, 32'd0, "score_no_eat");
        expect_at(0, K_PELL, 0, 32'd244, "pellets_no_eat");
        tick();

        // Pellet eat: player (100,100) -> centre tile (13,13), address 429.
        sprite(0, 100, 100, 12'hF00);
        wq0.push_back('{addr: 11'd429, data: 4'd0, score: 16'd10, pell: 9'd243, clr: 1'b0, pwr: 1'b0});
        frame('0);
        expect_at(0, K_SCORE, 0, 32'd10, "score_pellet");
        expect_at(0, K_PELL, 0, 32'd243, "pellets_pellet");
        expect_at(0, K_MEM, 429, 32'd0, "tile429_cleared");
        tick();

        // Power pellet on the same tile; a second frame must change nothing.
        poke(1'b0, 429, 4'd3);
        wq0.push_back('{addr: 11'd429, data: 4'd0, score: 16'd60, pell: 9'd242, clr: 1'b0, pwr: 1'b1});
        frame('0);
        frame('0);
        expect_at(0, K_SCORE, 0, 32'd60, "score_power");
        expect_at(0, K_PELL, 0, 32'd242, "pellets_power");
        expect_at(0, K_PCNT, 0, 32'd1, "power_stb_cycles");
        expect_at(0, K_MEM, 429, 32'd0, "tile429_cleared_again");
        tick();

        // Saturation instance: score FFFA + 10 and + 50 clamp; last pellet sets sticky level_clear.
        poke(1'b1, 429, 4'd2);
        wq1.push_back('{addr: 11'd429, data: 4'd0, score: 16'hFFFF, pell: 9'd0, clr: 1'b1, pwr: 1'b0});
        frame('0);
        poke(1'b1, 429, 4'd3);
        wq1.push_back('{addr: 11'd429, data: 4'd0, score: 16'hFFFF, pell: 9'd0, clr: 1'b1, pwr: 1'b1});
        frame('0);
        expect_at(0, K_SSCORE, 0, 32'hFFFF, "sat_score");
        expect_at(0, K_SPELL, 0, 32'd0, "sat_pellets");
        expect_at(0, K_SCLR, 0, 32'd1, "sat_level_clear");
        tick();

        // Centre row 36 is off the map: no read, no write, pellet there stays.
        poke(1'b0, 1165, 4'd2);
        sprite(0, 100, 284, 12'hF00);
        frame('0);
        expect_at(0, K_MEM, 1165, 32'd2, "offmap_tile_kept");
        expect_at(0, K_SCORE, 0, 32'd60, "offmap_score");
        tick();

        // Sprites: 0 and 2 overlap at (40,40); 3 straddles x=511.
        sprite(0, 40, 40, 12'hF00);
        sprite(2, 40, 40, 12'h0F0);
        sprite(3, 508, 100, 12'h0FF);
        b0.spr_en = 5'b01101;
        pix(42, 42, 1'b1, 12'hF00, "prio_42_42");
        pix(47, 47, 1'b1, 12'hF00, "prio_47_47");
        pix(48, 47, 1'b1, 12'h00F, "right_edge_out");
        pix(39, 42, 1'b1, 12'h00F, "left_edge_out");
        pix(510, 103, 1'b1, 12'h0FF, "spr3_510");
        pix(2, 103, 1'b1, 12'h00F, "spr3_no_wrap");
        pix(42, 42, 1'b0, 12'h000, "sprite_blanked");
        frame(5'b00100);
        frame('0);

        // Reset during CHECK of an eat: no write, everything back to reset values.
        b0.spr_en = '0;
        sprite(0, 100, 100, 12'hF00);
        poke(1'b0, 429, 4'd2);
        b0.frame_stb = 1'b1;
        tick();
        b0.frame_stb = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        expect_reset(1);
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        expect_at(0, K_MEM, 429, 32'd2, "rst_no_write_tile");
        tick();
        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL timeout: summary not reached by 100000 ns");
        $fatal(1, "timeout");
    end
endmodule
